// File: rtl/exp_max_align.sv
// exp_max_align: exponent max-finder and alignment-shift stage for the posit
// dot-product datapath. Sits after the per-lane product exponent adders.
//
// Picks the signed maximum exponent among the non-zero operands (N product
// lanes plus the accumulator). For each operand it produces the right-shift
// that aligns its mantissa to that maximum, saturated at ALIGN_WIDTH. Zero
// operands always get ALIGN_WIDTH. When every operand is zero, all_zero_o is
// set and max_exp_o is 0.
//
// Build option: `define EXP_ALIGN_PIPE2_EN for two register stages (latency 2).
// Without it the block is a single register stage (latency 1). Results are
// the same in both builds.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   in_valid_i / in_ready_o  input handshake
//   exp_i                    N packed signed exponents, EXP_WIDTH+1 bits each
//   zero_i                   per-lane zero/excluded flags
//   acc_exp_i, acc_zero_i    accumulator exponent and its zero flag
//   out_valid_o/out_ready_i  output handshake
//   max_exp_o                signed maximum exponent
//   shamt_o                  per-lane shift amounts, SHAMT_WIDTH bits each
//   acc_shamt_o              accumulator shift amount
//   all_zero_o               every operand flagged zero
//
// The derived widths are computed here with $clog2, so this file does not
// depend on any package.
module exp_max_align #(
  parameter int unsigned n           = 16,
  parameter int unsigned es          = 1,
  parameter int unsigned N           = 4,
  parameter int unsigned ALIGN_WIDTH = 32,
  parameter int unsigned LZC_WIDTH   = $clog2(n - 1),
  parameter int unsigned EXP_WIDTH   = LZC_WIDTH + 1 + es,
  parameter int unsigned SHAMT_WIDTH = $clog2(ALIGN_WIDTH + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic [N*(EXP_WIDTH+1)-1:0]     exp_i,
  input  logic [N-1:0]                   zero_i,
  input  logic [EXP_WIDTH:0]             acc_exp_i,
  input  logic                           acc_zero_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [EXP_WIDTH:0]             max_exp_o,
  output logic [N*SHAMT_WIDTH-1:0]       shamt_o,
  output logic [SHAMT_WIDTH-1:0]         acc_shamt_o,
  output logic                           all_zero_o
);

  localparam int unsigned EW1 = EXP_WIDTH + 1;
  localparam logic [SHAMT_WIDTH-1:0] SHAMT_SAT = SHAMT_WIDTH'(ALIGN_WIDTH);

  // The difference is taken at EXP_WIDTH+2 bits, so that extreme exponents
  // (-2^EXP_WIDTH against 2^EXP_WIDTH-1) cannot wrap.
  function automatic logic [SHAMT_WIDTH-1:0] shift_of(
    input logic signed [EXP_WIDTH:0] mx,
    input logic signed [EXP_WIDTH:0] e,
    input logic                      z
  );
    logic signed [EXP_WIDTH+1:0] d;
    d = (EXP_WIDTH + 2)'(mx) - (EXP_WIDTH + 2)'(e);
    if (z || (32'(d) > ALIGN_WIDTH))
      return SHAMT_SAT;
    return SHAMT_WIDTH'(d);
  endfunction

  // Maximum over the candidate set, taken directly from the inputs
  logic signed [EXP_WIDTH:0] in_max;
  logic                      in_any;

  always_comb begin
    in_max = '0;
    in_any = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!zero_i[i] && (!in_any || ($signed(exp_i[i*EW1 +: EW1]) > in_max))) begin
        in_max = exp_i[i*EW1 +: EW1];
        in_any = 1'b1;
      end
    end
    if (!acc_zero_i && (!in_any || ($signed(acc_exp_i) > in_max))) begin
      in_max = acc_exp_i;
      in_any = 1'b1;
    end
  end

  // Source feeding the output (shift) register: either the inputs directly,
  // or the stage A register when the two-stage build is selected.
  logic                      s_valid;
  logic                      s_ready;
  logic                      s_all_zero;
  logic signed [EXP_WIDTH:0] s_max;
  logic [N*EW1-1:0]          s_exp;
  logic [N-1:0]              s_zero;
  logic [EXP_WIDTH:0]        s_acc_exp;
  logic                      s_acc_zero;

  assign s_ready = !out_valid_o || out_ready_i;

`ifdef EXP_ALIGN_PIPE2_EN
  assign in_ready_o = !s_valid || s_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s_valid    <= 1'b0;
      s_all_zero <= 1'b0;
      s_max      <= '0;
      s_exp      <= '0;
      s_zero     <= '0;
      s_acc_exp  <= '0;
      s_acc_zero <= 1'b0;
    end else if (in_ready_o) begin
      s_valid <= in_valid_i;
      if (in_valid_i) begin
        s_all_zero <= !in_any;
        s_max      <= in_max;
        s_exp      <= exp_i;
        s_zero     <= zero_i;
        s_acc_exp  <= acc_exp_i;
        s_acc_zero <= acc_zero_i;
      end
    end
  end
`else
  assign in_ready_o = s_ready;
  assign s_valid    = in_valid_i;
  assign s_all_zero = !in_any;
  assign s_max      = in_max;
  assign s_exp      = exp_i;
  assign s_zero     = zero_i;
  assign s_acc_exp  = acc_exp_i;
  assign s_acc_zero = acc_zero_i;
`endif

  logic [N*SHAMT_WIDTH-1:0] s_shamt;
  logic [SHAMT_WIDTH-1:0]   s_acc_shamt;

  always_comb begin
    s_shamt = '0;
    for (int unsigned i = 0; i < N; i++)
      s_shamt[i*SHAMT_WIDTH +: SHAMT_WIDTH] = shift_of(s_max, s_exp[i*EW1 +: EW1], s_zero[i]);
    s_acc_shamt = shift_of(s_max, s_acc_exp, s_acc_zero);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_o <= 1'b0;
      max_exp_o   <= '0;
      shamt_o     <= '0;
      acc_shamt_o <= '0;
      all_zero_o  <= 1'b0;
    end else if (s_ready) begin
      out_valid_o <= s_valid;
      if (s_valid) begin
        max_exp_o   <= s_max;
        shamt_o     <= s_shamt;
        acc_shamt_o <= s_acc_shamt;
        all_zero_o  <= s_all_zero;
      end
    end
  end

endmodule

// File: tb/tb_exp_max_align.sv
// Testbench for exp_max_align (default parameters: N=4, 7-bit exponents,
// ALIGN_WIDTH=32). A reference model computes the expected outputs from the
// candidate set with plain integer arithmetic. Expected results are queued at
// acceptance and compared on every cycle that out_valid_o is high.
module tb_exp_max_align;
  localparam int NL  = 4;
  localparam int EW  = 6;
  localparam int SW  = 6;
  localparam int AW  = 32;
`ifdef EXP_ALIGN_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef int iarr_t[5];
  typedef bit barr_t[5];
  typedef struct {
    int mx;
    int sh[5];
    bit az;
    int cyc;
    bit seen;
  } res_t;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [NL*(EW+1)-1:0]  exp_bus = '0;
  logic [NL-1:0]         zero = '0;
  logic [EW:0]           acc_exp = '0;
  logic                  acc_zero = 1'b0;
  logic                  out_valid;
  logic                  out_ready = 1'b1;
  logic [EW:0]           max_exp;
  logic [NL*SW-1:0]      shamt;
  logic [SW-1:0]         acc_shamt;
  logic                  all_zero;

  exp_max_align #(.n(16), .es(1), .N(NL), .ALIGN_WIDTH(AW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .exp_i(exp_bus), .zero_i(zero), .acc_exp_i(acc_exp), .acc_zero_i(acc_zero),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .max_exp_o(max_exp),
    .shamt_o(shamt), .acc_shamt_o(acc_shamt), .all_zero_o(all_zero)
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  bit    strict_lat = 1'b1;
  bit    rand_done = 1'b0;
  res_t  q[$];
  iarr_t cur_e;
  barr_t cur_z;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Index 4 is the accumulator.
  function automatic res_t model(input iarr_t e, input barr_t z);
    res_t r;
    bit any = 1'b0;
    r.mx = 0;
    for (int i = 0; i < 5; i++)
      if (!z[i] && (!any || e[i] > r.mx)) begin
        r.mx = e[i];
        any = 1'b1;
      end
    for (int i = 0; i < 5; i++)
      r.sh[i] = z[i] ? AW : ((r.mx - e[i]) > AW ? AW : (r.mx - e[i]));
    r.az = !any;
    r.cyc = 0;
    r.seen = 1'b0;
    return r;
  endfunction

  task automatic drive(input iarr_t e, input barr_t z);
    cur_e = e;
    cur_z = z;
    for (int i = 0; i < NL; i++) begin
      exp_bus[i*(EW+1) +: EW+1] = e[i][EW:0];
      zero[i] = z[i];
    end
    acc_exp = e[4][EW:0];
    acc_zero = z[4];
  endtask

  // Called at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic send(input iarr_t e, input barr_t z);
    bit rdy;
    drive(e, z);
    in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    total++;
    bad++;
    $display("FAIL send_timeout: got no in_ready required in_ready=1");
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && q.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    check("drain_empty", q.size(), 0);
  endtask

  task automatic expect_out(input string tag, input int mx, input int s0, input int s1,
                            input int s2, input int s3, input int sa, input int az);
    check({tag, "_valid"}, int'(out_valid), 1);
    check({tag, "_max"}, int'($signed(max_exp)), mx);
    check({tag, "_sh0"}, int'(shamt[0*SW +: SW]), s0);
    check({tag, "_sh1"}, int'(shamt[1*SW +: SW]), s1);
    check({tag, "_sh2"}, int'(shamt[2*SW +: SW]), s2);
    check({tag, "_sh3"}, int'(shamt[3*SW +: SW]), s3);
    check({tag, "_acc"}, int'(acc_shamt), sa);
    check({tag, "_az"}, int'(all_zero), az);
  endtask

  task automatic wait_result();
    for (int k = 1; k < LAT; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Compare process: sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got out_valid=1 required no pending result");
        end else begin
          check("max_exp", int'($signed(max_exp)), q[0].mx);
          for (int i = 0; i < NL; i++)
            check($sformatf("shamt%0d", i), int'(shamt[i*SW +: SW]), q[0].sh[i]);
          check("acc_shamt", int'(acc_shamt), q[0].sh[4]);
          check("all_zero", int'(all_zero), int'(q[0].az));
          if (!q[0].seen) begin
            q[0].seen = 1'b1;
            if (strict_lat) check("latency", cyc - q[0].cyc, LAT);
          end
          if (out_ready) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        res_t r;
        r = model(cur_e, cur_z);
        r.cyc = cyc;
        q.push_back(r);
      end
    end
  end

  function automatic int rexp();
    int r = $urandom_range(0, 9);
    if (r == 0) return -64;
    if (r == 1) return 63;
    return int'($urandom_range(0, 127)) - 64;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    iarr_t e;
    barr_t z;
    barr_t nz;
    barr_t az;
    res_t  m;
    nz = '{0, 0, 0, 0, 0};
    az = '{1, 1, 1, 1, 1};

    // Reset values
    #6;
    check("rst_valid", int'(out_valid), 0);
    check("rst_max", int'(max_exp), 0);
    check("rst_shamt", int'(shamt), 0);
    check("rst_acc_shamt", int'(acc_shamt), 0);
    check("rst_all_zero", int'(all_zero), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;

    // Model pinned against hand-computed values
    m = model('{5, -3, 0, 5, 2}, nz);
    check("model_t1_max", m.mx, 5);
    check("model_t1_sh1", m.sh[1], 8);
    check("model_t1_acc", m.sh[4], 3);
    m = model('{40, -40, 0, 0, -64}, nz);
    check("model_t2_sh1", m.sh[1], 32);
    check("model_t2_sh2", m.sh[2], 32);
    m = model('{9, -20, -7, 60, 1}, '{1, 1, 0, 1, 1});
    check("model_t3_max", m.mx, -7);
    check("model_t3_sh2", m.sh[2], 0);

    // Basic alignment
    send('{5, -3, 0, 5, 2}, nz);
    wait_result();
    expect_out("t1", 5, 0, 8, 5, 0, 3, 0);
    // Saturation
    send('{40, -40, 0, 0, -64}, nz);
    wait_result();
    expect_out("t2", 40, 0, 32, 32, 32, 32, 0);
    // All zero, then a single surviving lane
    send('{9, -20, 3, 60, 1}, az);
    wait_result();
    expect_out("t3a", 0, 32, 32, 32, 32, 32, 1);
    send('{9, -20, -7, 60, 1}, '{1, 1, 0, 1, 1});
    wait_result();
    expect_out("t3b", -7, 32, 32, 0, 32, 32, 0);
    // Extremes
    send('{63, -64, 0, -64, 63}, nz);
    wait_result();
    expect_out("t_ext", 63, 0, 32, 32, 32, 0, 0);
    drain();

    // Backpressure: two sets with the consumer stalled
    strict_lat = 1'b0;
    out_ready = 1'b0;
    fork
      begin
        send('{1, 2, 3, 4, 0}, nz);
        send('{-5, -6, -7, -8, -10}, nz);
      end
      begin
        repeat (4) @(negedge clk);
        check("full_in_ready", int'(in_ready), 0);
        check("full_valid", int'(out_valid), 1);
        check("full_held_max", int'($signed(max_exp)), 4);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Asynchronous reset while a result is held
    out_ready = 1'b0;
    send('{10, 11, 12, 13, 14}, nz);
    wait_result();
    check("pre_rst_valid", int'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", int'(out_valid), 0);
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    send('{5, -3, 0, 5, 2}, nz);
    wait_result();
    expect_out("post_rst", 5, 0, 8, 5, 0, 3, 0);
    drain();

    // Back-to-back stream with latency checking
    strict_lat = 1'b1;
    for (int s = 0; s < 8; s++) begin
      for (int i = 0; i < 5; i++) begin
        e[i] = rexp();
        z[i] = ($urandom_range(0, 4) == 0);
      end
      send(e, z);
    end
    drain();

    // Random traffic with random backpressure
    strict_lat = 1'b0;
    fork
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        for (int s = 0; s < 1500; s++) begin
          for (int i = 0; i < 5; i++) begin
            e[i] = rexp();
            z[i] = (s % 16 == 7) ? 1'b1 : ($urandom_range(0, 3) == 0);
          end
          send(e, z);
          if ($urandom_range(0, 9) < 3) begin
            @(posedge clk);
            #1;
          end
        end
        rand_done = 1'b1;
      end
    join
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
